mem_io_bridge: RTL and testbench

- Second-generation memory/IO bridge between the CPU's MEM stage, data memory and board peripherals.
- Decodes the IO window at the top of the address space. Holds registered LED and seven-segment output registers.
- Synchronises switch, keypad and button inputs. Latches keypad and button events, which are cleared when the CPU reads them.
- Returns read data with a fixed one-cycle latency, aligned to the block-RAM read latency.

---
 rtl/mem_io_bridge.sv | 107 ++++++++++
 tb/tb_mem_io_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: MEM-stage bridge to data memory and board IO, with one-cycle read latency.
module mem_io_bridge #(
  parameter logic [31:0] IO_BASE = 32'hFFFFFC00,
  parameter int LED_W = 16,
  parameter int SW_W = 16,
  parameter int KEY_W = 12,
  parameter int SEG_DIGITS = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mRead,
  input  logic                  mWrite,
  input  logic                  ioRead,
  input  logic                  ioWrite,
  input  logic [31:0]           addr_in,
  input  logic [31:0]           wdata_in,
  output logic [31:0]           addr_out,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           r_wdata,
  output logic                  rdata_valid,
  output logic                  io_err,
  input  logic [SW_W-1:0]       switch_in,
  input  logic [KEY_W-1:0]      key_in,
  input  logic                  key_strobe,
  input  logic                  btn_in,
  output logic [LED_W-1:0]      led_out,
  output logic [31:0]           seg_value,
  output logic [SEG_DIGITS-1:0] seg_en
);
  localparam int ST = SYNC_STAGES;
  logic [ST-1:0][SW_W-1:0] sw_s;
  logic [ST-1:0][KEY_W+1:0] ev_s;
  logic [SW_W-1:0] sw_y;
  logic [KEY_W+1:0] ev_y;
  logic ks_p, bt_p, key_edge, btn_edge, key_pend, btn_pend, mem_sel;
  logic [KEY_W-1:0] key_code;
  logic [2:0] n_strb;
  logic [7:0] off;
  logic io_hit, multi, is_rw, mapped, bad, rd, io_rd, io_wr;
  logic [31:0] io_val, r_q;
  assign addr_out = addr_in;
  assign mem_wdata = wdata_in;
  assign sw_y = sw_s[ST-1];
  assign ev_y = ev_s[ST-1];
  assign key_edge = ev_y[KEY_W+1] & ~ks_p;
  assign btn_edge = ev_y[KEY_W] & ~bt_p;
  assign off = addr_in[7:0];
  assign io_hit = addr_in[31:8] == IO_BASE[31:8];
  assign n_strb = 3'(mRead) + 3'(mWrite) + 3'(ioRead) + 3'(ioWrite);
  assign multi = n_strb > 3'd1;
  assign is_rw = off == 8'h60 || off == 8'h6C || off == 8'h70;
  assign mapped = is_rw || off == 8'h64 || off == 8'h68 || off == 8'h80;
  assign bad = multi | ((ioRead | ioWrite) & ~io_hit) | ((mRead | mWrite) & io_hit) |
               ((ioRead | ioWrite) & io_hit & ~mapped) | (ioWrite & io_hit & ~is_rw);
  assign rd = (mRead | ioRead) & ~multi;
  assign io_rd = ioRead & ~bad;
  assign io_wr = ioWrite & ~bad;
  assign mem_we = mWrite & ~bad;
  // Memory data arrives a cycle late, so it is passed straight through and captured for hold.
  assign r_wdata = mem_sel ? mem_rdata : r_q;
  always_comb
    io_val = off == 8'h60 ? 32'(led_out) :
             off == 8'h64 ? 32'(sw_y) :
             off == 8'h68 ? (32'(key_code) | {key_pend, 31'b0}) :
             off == 8'h6C ? seg_value :
             off == 8'h70 ? 32'(seg_en) :
             off == 8'h80 ? {31'b0, btn_pend} : 32'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sw_s <= '0;
      ev_s <= '0;
      ks_p <= 1'b0;
      bt_p <= 1'b0;
      key_code <= '0;
      key_pend <= 1'b0;
      btn_pend <= 1'b0;
      led_out <= '0;
      seg_value <= '0;
      seg_en <= '1;
      r_q <= '0;
      mem_sel <= 1'b0;
      rdata_valid <= 1'b0;
      io_err <= 1'b0;
    end else begin
      sw_s <= {sw_s[ST-2:0], switch_in};
      ev_s <= {ev_s[ST-2:0], {key_strobe, btn_in, key_in}};
      ks_p <= ev_y[KEY_W+1];
      bt_p <= ev_y[KEY_W];
      io_err <= bad;
      rdata_valid <= rd;
      mem_sel <= mRead & ~bad;
      r_q <= (rd & bad) ? 32'b0 : io_rd ? io_val : mem_sel ? mem_rdata : r_q;
      if (io_wr && off == 8'h60) led_out <= wdata_in[LED_W-1:0];
      if (io_wr && off == 8'h6C) seg_value <= wdata_in;
      if (io_wr && off == 8'h70) seg_en <= wdata_in[SEG_DIGITS-1:0];
      // An edge arriving with a read-clear wins so no event is lost.
      if (key_edge) begin
        key_code <= ev_y[KEY_W-1:0];
        key_pend <= 1'b1;
      end else if (io_rd && off == 8'h68) key_pend <= 1'b0;
      if (btn_edge) btn_pend <= 1'b1;
      else if (io_rd && off == 8'h80) btn_pend <= 1'b0;
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed and randomized checks of mem_io_bridge against a behavioural model.
module tb_mem_io_bridge;
  localparam int ST = 2;
  logic clk = 0, rst_n = 0;
  logic mRead = 0, mWrite = 0, ioRead = 0, ioWrite = 0;
  logic [31:0] addr_in = 0, wdata_in = 0, mem_rdata = 0;
  logic [31:0] addr_out, mem_wdata, r_wdata, seg_value;
  logic mem_we, rdata_valid, io_err;
  logic [15:0] switch_in = 0, led_out;
  logic [11:0] key_in = 0;
  logic key_strobe = 0, btn_in = 0;
  logic [7:0] seg_en;
  int n_cmp = 0, n_bad = 0;
  mem_io_bridge dut (
    .clk(clk), .rst_n(rst_n), .mRead(mRead), .mWrite(mWrite), .ioRead(ioRead), .ioWrite(ioWrite),
    .addr_in(addr_in), .wdata_in(wdata_in), .addr_out(addr_out), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .r_wdata(r_wdata), .rdata_valid(rdata_valid),
    .io_err(io_err), .switch_in(switch_in), .key_in(key_in), .key_strobe(key_strobe),
    .btn_in(btn_in), .led_out(led_out), .seg_value(seg_value), .seg_en(seg_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Behavioural model: board inputs seen ST cycles late, registers as plain variables.
  logic [15:0] m_led, h_sw[ST+1];
  logic [31:0] m_seg, m_last;
  logic [7:0] m_segen;
  logic [11:0] m_code, h_key[ST+1];
  logic m_kp, m_bp, e_valid, e_err, e_mem;
  logic h_ks[ST+1], h_bt[ST+1];
  always @(posedge clk) begin
    if (!rst_n) begin
      m_led = 0; m_seg = 0; m_segen = 8'hFF; m_code = 0; m_kp = 0; m_bp = 0;
      m_last = 0; e_valid = 0; e_err = 0; e_mem = 0;
      for (int j = 0; j <= ST; j++) begin
        h_sw[j] = 0; h_key[j] = 0; h_ks[j] = 0; h_bt[j] = 0;
      end
    end else begin
      int cnt;
      logic hit, illegal, kclr, bclr;
      logic [7:0] o;
      logic [31:0] val;
      if (e_mem) m_last = mem_rdata;
      cnt = int'(mRead) + int'(mWrite) + int'(ioRead) + int'(ioWrite);
      hit = addr_in[31:8] == 24'hFFFFFC;
      o = addr_in[7:0];
      illegal = 0;
      if (cnt > 1) illegal = 1;
      else if (ioRead || ioWrite) begin
        if (!hit) illegal = 1;
        else if (!(o inside {8'h60, 8'h64, 8'h68, 8'h6C, 8'h70, 8'h80})) illegal = 1;
        else if (ioWrite && !(o inside {8'h60, 8'h6C, 8'h70})) illegal = 1;
      end else if ((mRead || mWrite) && hit) illegal = 1;
      case (o)
        8'h60: val = {16'b0, m_led};
        8'h64: val = {16'b0, h_sw[ST-1]};
        8'h68: val = {m_kp, 19'b0, m_code};
        8'h6C: val = m_seg;
        8'h70: val = {24'b0, m_segen};
        default: val = {31'b0, m_bp};
      endcase
      e_mem = 0; e_valid = 0; e_err = illegal;
      if (cnt == 1 && (mRead || ioRead)) begin
        e_valid = 1;
        if (illegal) m_last = 0;
        else if (ioRead) m_last = val;
        else e_mem = 1;
      end
      if (ioWrite && !illegal) begin
        if (o == 8'h60) m_led = wdata_in[15:0];
        if (o == 8'h6C) m_seg = wdata_in;
        if (o == 8'h70) m_segen = wdata_in[7:0];
      end
      kclr = ioRead && !illegal && o == 8'h68;
      bclr = ioRead && !illegal && o == 8'h80;
      if (h_ks[ST-1] && !h_ks[ST]) begin
        m_code = h_key[ST-1]; m_kp = 1;
      end else if (kclr) m_kp = 0;
      if (h_bt[ST-1] && !h_bt[ST]) m_bp = 1;
      else if (bclr) m_bp = 0;
      for (int j = ST; j > 0; j--) begin
        h_sw[j] = h_sw[j-1]; h_key[j] = h_key[j-1]; h_ks[j] = h_ks[j-1]; h_bt[j] = h_bt[j-1];
      end
      h_sw[0] = switch_in; h_key[0] = key_in; h_ks[0] = key_strobe; h_bt[0] = btn_in;
    end
  end
  always @(negedge clk)
    if (rst_n) begin
      chk("m_r_wdata", r_wdata, e_mem ? mem_rdata : m_last);
      chk("m_valid", 32'(rdata_valid), 32'(e_valid));
      chk("m_io_err", 32'(io_err), 32'(e_err));
      chk("m_led", 32'(led_out), 32'(m_led));
      chk("m_seg", seg_value, m_seg);
      chk("m_segen", 32'(seg_en), 32'(m_segen));
      chk("m_mem_we", 32'(mem_we), 32'(mWrite && !mRead && !ioRead && !ioWrite && addr_in[31:8] != 24'hFFFFFC));
      chk("m_pass", {addr_out ^ addr_in} | {mem_wdata ^ wdata_in}, 32'b0);
    end
  task automatic drive(input logic mr, mw, ir, iw, input logic [31:0] a, d);
    @(posedge clk); #1;
    mRead = mr; mWrite = mw; ioRead = ir; ioWrite = iw; addr_in = a; wdata_in = d;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
  endtask
  task automatic io_read_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    drive(0, 0, 1, 0, a, 0);
    idle();
    @(negedge clk);
    chk(name, r_wdata, exp);
    chk({name, "_v"}, 32'(rdata_valid), 1);
  endtask
  logic [7:0] offs[6] = '{8'h60, 8'h64, 8'h68, 8'h6C, 8'h70, 8'h80};
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_led", 32'(led_out), 0);
    chk("rst_segen", 32'(seg_en), 32'hFF);
    chk("rst_r", r_wdata, 0);
    chk("rst_v", 32'(rdata_valid), 0);
    drive(0, 0, 0, 1, 32'hFFFFFC60, 32'h0000A5A5);
    idle();
    @(negedge clk);
    chk("led_wr", 32'(led_out), 32'hA5A5);
    io_read_chk(32'hFFFFFC60, 32'h0000A5A5, "led_rd");
    drive(0, 1, 0, 0, 32'h00000010, 32'h12345678);
    @(negedge clk);
    chk("mem_we", 32'(mem_we), 1);
    drive(1, 0, 0, 0, 32'h00000010, 0);
    idle();
    mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("mem_rd", r_wdata, 32'h12345678);
    chk("mem_rd_v", 32'(rdata_valid), 1);
    key_in = 12'h0AB; key_strobe = 1;
    repeat (4) idle();
    key_strobe = 0;
    repeat (4) idle();
    io_read_chk(32'hFFFFFC68, 32'h800000AB, "key_rd1");
    io_read_chk(32'hFFFFFC68, 32'h000000AB, "key_rd2");
    btn_in = 1;
    repeat (4) idle();
    btn_in = 0;
    repeat (4) idle();
    idle();
    btn_in = 1;
    repeat (ST - 1) idle();
    io_read_chk(32'hFFFFFC80, 32'h1, "btn_coinc");
    io_read_chk(32'hFFFFFC80, 32'h1, "btn_rd2");
    io_read_chk(32'hFFFFFC80, 32'h0, "btn_rd3");
    drive(0, 0, 0, 1, 32'hFFFFFC64, 32'hFFFFFFFF);
    idle();
    @(negedge clk);
    chk("err_ro", 32'(io_err), 1);
    drive(0, 0, 1, 0, 32'hFFFFFC90, 0);
    idle();
    @(negedge clk);
    chk("err_unmap", 32'(io_err), 1);
    chk("err_unmap_r", r_wdata, 0);
    drive(0, 1, 0, 0, 32'hFFFFFC60, 32'h1111);
    @(negedge clk);
    chk("err_mw_we", 32'(mem_we), 0);
    drive(1, 0, 0, 0, 32'hFFFFFC60, 0);
    idle();
    @(negedge clk);
    chk("err_mr", 32'(io_err), 1);
    chk("err_mr_v", 32'(rdata_valid), 1);
    drive(1, 0, 1, 0, 32'hFFFFFC60, 0);
    idle();
    @(negedge clk);
    chk("err_multi", 32'(io_err), 1);
    chk("err_multi_v", 32'(rdata_valid), 0);
    chk("err_led", 32'(led_out), 32'hA5A5);
    for (int i = 0; i < 3000; i++) begin
      int k, s;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      s = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: a = {24'hFFFFFC, offs[$urandom_range(0, 5)]};
        1: a = {24'hFFFFFC, 8'($urandom)};
        default: a = $urandom;
      endcase
      if (k < 2) idle();
      else if (k == 2) drive(1'($urandom), 1, 1'($urandom), 1'($urandom), a, $urandom);
      else drive(s == 0, s == 1, s == 2, s == 3, a, $urandom);
      mem_rdata = $urandom;
      if ($urandom_range(0, 7) == 0) switch_in = 16'($urandom);
      key_in = 12'($urandom);
      if ($urandom_range(0, 5) == 0) key_strobe = ~key_strobe;
      if ($urandom_range(0, 4) == 0) btn_in = ~btn_in;
    end
    repeat (3) idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
